player_motion_ctrl: RTL and testbench

//  Parametrised player controller for the Fireboy/Icegirl sprites: one instance per character.
//  Per frame tick, integrates X/Y motion with gravity, jump, bounds clamping and ground detection.

---
 rtl/player_pkg.sv | 15 +
 rtl/player_anim_seq.sv | 65 ++++++
 rtl/player_motion_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types for the Fireboy/Icegirl player controller.
package player_pkg;

    localparam int POS_W = 10;

    typedef logic signed [10:0] vel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2,
        FALL = 2'd3
    } anim_t;

endpackage

// File: rtl/player_anim_seq.sv
// Animation sequencer: picks Idle/Run/Jump/Fall from the post-update motion
// state and steps the frame index every ANIM_DIV ticks.
module player_anim_seq
    import player_pkg::*;
#(
    parameter int ANIM_FRAMES = 4,
    parameter int ANIM_DIV    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_revive,
    input  logic       i_tick,
    input  logic       i_grounded,
    input  logic       i_vy_neg,
    input  logic       i_vx_nz,
    output logic [1:0] o_anim_type,
    output logic [2:0] o_frame_index
);

    localparam int AC_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_JUMP = JUMP;
    localparam logic [1:0] ST_FALL = FALL;

    logic [1:0]      r_state;
    logic [2:0]      r_frame;
    logic [AC_W-1:0] r_cnt;
    logic [1:0]      w_state_nxt;

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (!i_grounded && i_vy_neg) w_state_nxt = ST_JUMP;
        else if (!i_grounded)        w_state_nxt = ST_FALL;
        else if (i_vx_nz)            w_state_nxt = ST_RUN;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_frame <= 3'd0;
            r_cnt   <= '0;
        end else if (i_revive) begin
            r_state <= ST_IDLE;
            r_frame <= 3'd0;
            r_cnt   <= '0;
        end else if (i_tick) begin
            if (w_state_nxt != r_state) begin
                r_state <= w_state_nxt;
                r_frame <= 3'd0;
                r_cnt   <= '0;
            end else if (r_cnt == AC_W'(ANIM_DIV - 1)) begin
                r_cnt   <= '0;
                r_frame <= (r_frame == 3'(ANIM_FRAMES - 1)) ? 3'd0 : r_frame + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_anim_type   = r_state;
    assign o_frame_index = r_frame;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-character motion, facing and sprite-hit logic, stepped once per frame tick.
// Optional mid-air second jump is built when PLAYER_DOUBLE_JUMP_EN is defined.
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int HEIGHT      = 48,
    parameter int START_X     = 32,
    parameter int START_Y     = 416,
    parameter int VMAX_X      = 2,
    parameter int JUMP_V0     = 7,
    parameter int GRAVITY     = 1,
    parameter int GRAV_DIV    = 4,
    parameter int VMAX_FALL   = 8,
    parameter int ANIM_FRAMES = 4,
    parameter int ANIM_DIV    = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        revive,
    input  logic        jump,
    input  logic        left,
    input  logic        right,
    input  logic [9:0]  x_min,
    input  logic [9:0]  x_max,
    input  logic [9:0]  y_min,
    input  logic [9:0]  y_max,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        grounded,
    output logic [1:0]  anim_type,
    output logic [2:0]  frame_index,
    output logic        facing_left,
    output logic        is_player,
    output logic [10:0] sprite_addr
);

    localparam int GC_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic signed [11:0] W_S  = 12'(WIDTH);
    localparam logic signed [11:0] H_S  = 12'(HEIGHT);
    localparam logic signed [11:0] VX_S = 12'(VMAX_X);
    localparam vel_t JV_S = 11'(JUMP_V0);
    localparam vel_t G_S  = 11'(GRAVITY);
    localparam vel_t VF_S = 11'(VMAX_FALL);

    logic               r_fc_d, r_tick;
    logic [POS_W-1:0]   r_pos_x, r_pos_y;
    vel_t               r_vy;
    logic [GC_W-1:0]    r_grav_cnt;
    logic               r_grounded, r_facing_left;

    logic signed [11:0] w_vx, w_nx, w_ny, w_nx_c, w_ny_c;
    logic signed [11:0] w_x_min_s, w_x_max_s, w_y_min_s, w_y_max_s;
    vel_t               w_vy_sum, w_vy_grav, w_vy_nxt, w_vy_fin;
    logic [GC_W-1:0]    w_grav_cnt_nxt;
    logic               w_grounded_nxt, w_facing_nxt, w_jump_go, w_air_go;
    logic [10:0]        w_off_x, w_off_y, w_col;

    assign w_x_min_s = $signed({2'b00, x_min});
    assign w_x_max_s = $signed({2'b00, x_max});
    assign w_y_min_s = $signed({2'b00, y_min});
    assign w_y_max_s = $signed({2'b00, y_max});
    assign w_jump_go = jump & r_grounded;

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic r_air_jump, r_jump_prev;
    assign w_air_go = ~r_grounded & r_air_jump & jump & ~r_jump_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_air_jump  <= 1'b1;
            r_jump_prev <= 1'b0;
        end else if (revive) begin
            r_air_jump  <= 1'b1;
            r_jump_prev <= 1'b0;
        end else if (r_tick) begin
            r_jump_prev <= jump;
            if (w_grounded_nxt)  r_air_jump <= 1'b1;
            else if (w_air_go)   r_air_jump <= 1'b0;
        end
    end
`else
    assign w_air_go = 1'b0;
`endif

    always_comb begin
        w_vx = 12'sd0;
        if (left)       w_vx = -VX_S;
        else if (right) w_vx = VX_S;
        w_facing_nxt = left ? 1'b1 : (right ? 1'b0 : r_facing_left);

        w_grav_cnt_nxt = r_grav_cnt + 1'b1;
        w_vy_sum       = r_vy + G_S;
        w_vy_grav      = r_vy;
        if (r_grav_cnt == GC_W'(GRAV_DIV - 1)) begin
            w_grav_cnt_nxt = '0;
            w_vy_grav      = (w_vy_sum > VF_S) ? VF_S : w_vy_sum;
        end
        // A launch replaces whatever gravity did this tick.
        w_vy_nxt = (w_jump_go | w_air_go) ? -JV_S : w_vy_grav;

        w_nx = $signed({2'b00, r_pos_x}) + w_vx;
        w_ny = $signed({2'b00, r_pos_y}) + $signed({w_vy_nxt[10], w_vy_nxt});

        w_nx_c = w_nx;
        if (w_nx < w_x_min_s)                       w_nx_c = w_x_min_s;
        else if (w_nx + W_S > w_x_max_s + 12'sd1)   w_nx_c = w_x_max_s - W_S + 12'sd1;

        w_ny_c         = w_ny;
        w_vy_fin       = w_vy_nxt;
        w_grounded_nxt = 1'b0;
        if (w_ny < w_y_min_s) begin
            w_ny_c   = w_y_min_s;
            w_vy_fin = '0;
        end else if ((w_ny + H_S >= w_y_max_s + 12'sd1) && !w_vy_nxt[10]) begin
            w_ny_c         = w_y_max_s - H_S + 12'sd1;
            w_vy_fin       = '0;
            w_grounded_nxt = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fc_d        <= 1'b0;
            r_tick        <= 1'b0;
            r_pos_x       <= 10'(START_X);
            r_pos_y       <= 10'(START_Y);
            r_vy          <= '0;
            r_grav_cnt    <= '0;
            r_grounded    <= 1'b1;
            r_facing_left <= 1'b0;
        end else begin
            r_fc_d <= frame_clk;
            if (revive) begin
                r_tick        <= 1'b0;
                r_pos_x       <= 10'(START_X);
                r_pos_y       <= 10'(START_Y);
                r_vy          <= '0;
                r_grav_cnt    <= '0;
                r_grounded    <= 1'b1;
                r_facing_left <= 1'b0;
            end else begin
                r_tick <= frame_clk & ~r_fc_d;
                if (r_tick) begin
                    r_pos_x       <= w_nx_c[POS_W-1:0];
                    r_pos_y       <= w_ny_c[POS_W-1:0];
                    r_vy          <= w_vy_fin;
                    r_grav_cnt    <= w_grav_cnt_nxt;
                    r_grounded    <= w_grounded_nxt;
                    r_facing_left <= w_facing_nxt;
                end
            end
        end
    end

    player_anim_seq #(
        .ANIM_FRAMES (ANIM_FRAMES),
        .ANIM_DIV    (ANIM_DIV)
    ) u_anim (
        .i_clk         (Clk),
        .i_rst         (Reset),
        .i_revive      (revive),
        .i_tick        (r_tick),
        .i_grounded    (w_grounded_nxt),
        .i_vy_neg      (w_vy_fin[10]),
        .i_vx_nz       (w_vx != 12'sd0),
        .o_anim_type   (anim_type),
        .o_frame_index (frame_index)
    );

    // Offsets wrap modulo 2048 so pixels left/above the sprite read as huge.
    assign w_off_x     = {1'b0, DrawX} - {1'b0, r_pos_x};
    assign w_off_y     = {1'b0, DrawY} - {1'b0, r_pos_y};
    assign is_player   = (w_off_x < 11'(WIDTH)) && (w_off_y < 11'(HEIGHT));
    assign w_col       = r_facing_left ? (11'(WIDTH - 1) - w_off_x) : w_off_x;
    assign sprite_addr = is_player ? (w_off_y * 11'(WIDTH) + w_col) : 11'd0;

    assign pos_x       = r_pos_x;
    assign pos_y       = r_pos_y;
    assign grounded    = r_grounded;
    assign facing_left = r_facing_left;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios plus randomized keys and
// bounds, compared against an integer model of the motion rules.
module tb_player_motion_ctrl;

    localparam int WIDTH       = 32;
    localparam int HEIGHT      = 48;
    localparam int START_X     = 32;
    localparam int START_Y     = 416;
    localparam int VMAX_X      = 2;
    localparam int JUMP_V0     = 7;
    localparam int GRAVITY     = 1;
    localparam int GRAV_DIV    = 4;
    localparam int VMAX_FALL   = 8;
    localparam int ANIM_FRAMES = 4;
    localparam int ANIM_DIV    = 4;

    logic        Clk = 1'b0;
    logic        Reset, frame_clk, revive, jump, left, right;
    logic [9:0]  x_min, x_max, y_min, y_max, DrawX, DrawY;
    logic [9:0]  pos_x, pos_y;
    logic        grounded, facing_left, is_player;
    logic [1:0]  anim_type;
    logic [2:0]  frame_index;
    logic [10:0] sprite_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers).
    int m_x, m_y, m_vy, m_gc, m_grounded, m_facing, m_anim, m_frame, m_acnt;

    player_motion_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .revive      (revive),
        .jump        (jump),
        .left        (left),
        .right       (right),
        .x_min       (x_min),
        .x_max       (x_max),
        .y_min       (y_min),
        .y_max       (y_max),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .grounded    (grounded),
        .anim_type   (anim_type),
        .frame_index (frame_index),
        .facing_left (facing_left),
        .is_player   (is_player),
        .sprite_addr (sprite_addr)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_vy = 0; m_gc = 0; m_grounded = 1;
        m_facing = 0; m_anim = 0; m_frame = 0; m_acnt = 0;
    endtask

    // One frame of motion, computed from the current key and bound levels.
    task automatic model_step();
        int vx, nvy, nx, ny, g, na;
        vx = left ? -VMAX_X : (right ? VMAX_X : 0);
        if (left) m_facing = 1;
        else if (right) m_facing = 0;
        nvy = m_vy;
        if (m_gc == GRAV_DIV - 1) begin
            nvy = m_vy + GRAVITY;
            if (nvy > VMAX_FALL) nvy = VMAX_FALL;
        end
        m_gc = (m_gc + 1) % GRAV_DIV;
        if (jump && m_grounded == 1) nvy = -JUMP_V0;
        nx = m_x + vx;
        if (nx < int'(x_min)) nx = int'(x_min);
        else if (nx + WIDTH > int'(x_max) + 1) nx = int'(x_max) - WIDTH + 1;
        ny = m_y + nvy;
        g = 0;
        if (ny < int'(y_min)) begin
            ny = int'(y_min);
            nvy = 0;
        end else if (ny + HEIGHT >= int'(y_max) + 1 && nvy >= 0) begin
            ny = int'(y_max) - HEIGHT + 1;
            nvy = 0;
            g = 1;
        end
        m_x = nx; m_y = ny; m_vy = nvy; m_grounded = g;
        if (g == 0 && nvy < 0) na = 2;
        else if (g == 0)       na = 3;
        else if (vx != 0)      na = 1;
        else                   na = 0;
        if (na != m_anim) begin
            m_anim = na; m_frame = 0; m_acnt = 0;
        end else begin
            m_acnt++;
            if (m_acnt == ANIM_DIV) begin
                m_acnt = 0;
                m_frame = (m_frame + 1) % ANIM_FRAMES;
            end
        end
    endtask

    task automatic frame_tick();
        model_step();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic do_revive(input logic with_jump);
        @(negedge Clk);
        revive = 1'b1;
        jump = with_jump;
        @(negedge Clk);
        revive = 1'b0;
        jump = 1'b0;
        model_reset();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pos_x"},    int'(pos_x),       m_x);
        check({tag, ".pos_y"},    int'(pos_y),       m_y);
        check({tag, ".grounded"}, int'(grounded),    m_grounded);
        check({tag, ".anim"},     int'(anim_type),   m_anim);
        check({tag, ".frame"},    int'(frame_index), m_frame);
        check({tag, ".facing"},   int'(facing_left), m_facing);
    endtask

    task automatic check_render(input string tag, input int dx, input int dy);
        int ox, oy, col, isp, addr;
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        #1;
        ox = (int'(DrawX) - m_x) & 'h7FF;
        oy = (int'(DrawY) - m_y) & 'h7FF;
        isp = (ox < WIDTH && oy < HEIGHT) ? 1 : 0;
        col = (m_facing == 1) ? (WIDTH - 1 - ox) : ox;
        addr = (isp == 1) ? (oy * WIDTH + col) : 0;
        check({tag, ".is_player"}, int'(is_player), isp);
        check({tag, ".addr"}, int'(sprite_addr), addr);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; revive = 1'b0;
        jump = 1'b0; left = 1'b0; right = 1'b0;
        x_min = 10'd0; x_max = 10'd639; y_min = 10'd0; y_max = 10'd463;
        DrawX = 10'd0; DrawY = 10'd0;
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_state("reset");
        check("reset_pos_x", int'(pos_x), 32);
        check("reset_pos_y", int'(pos_y), 416);

        for (int i = 0; i < 8; i++) begin
            frame_tick();
            check_state("idle");
        end

        right = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame_tick();
            check_state("run");
        end
        right = 1'b0;
        check("run_pos_x", int'(pos_x), 52);
        check("run_frame", int'(frame_index), 2);
        check("run_anim", int'(anim_type), 1);

        jump = 1'b1;
        frame_tick();
        jump = 1'b0;
        check_state("jump");
        check("jump_pos_y", int'(pos_y), 409);
        check("jump_anim", int'(anim_type), 2);
        for (int i = 0; i < 60 && m_grounded == 0; i++) begin
            frame_tick();
            check_state("air");
        end
        check("land_grounded", int'(grounded), 1);
        check("land_pos_y", int'(pos_y), 416);
        check("land_anim", int'(anim_type), 0);

        jump = 1'b1;
        frame_tick();
        jump = 1'b0;
        repeat (3) frame_tick();
        check("mid_air", int'(grounded), 0);
        do_revive(1'b1);
        check_state("revive");

        x_min = 10'd30;
        left = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame_tick();
            check_state("left_clamp");
            check("left_clamp_x", int'(pos_x), 30);
        end
        left = 1'b0;
        check("left_facing", int'(facing_left), 1);

        check_render("hit", m_x, m_y + 1);
        check("hit_addr63", int'(sprite_addr), 63);
        check_render("miss", m_x + 32, m_y + 1);
        check("miss_addr0", int'(sprite_addr), 0);

        for (int i = 0; i < 250; i++) begin
            left  = ($urandom_range(0, 3) == 0);
            right = ($urandom_range(0, 2) == 0);
            jump  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) begin
                x_min = 10'($urandom_range(0, 40));
                x_max = 10'($urandom_range(600, 639));
                y_min = 10'($urandom_range(0, 20));
                y_max = 10'($urandom_range(440, 479));
            end
            if ($urandom_range(0, 39) == 0) begin
                do_revive(1'b1);
                check_state("rnd_revive");
            end else begin
                frame_tick();
                check_state("rnd");
            end
            check_render("rnd_in", m_x + int'($urandom_range(0, 36)) - 2,
                         m_y + int'($urandom_range(0, 52)) - 2);
            check_render("rnd_any", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
